uart_packet_rx: RTL
===================

// Module: uart_packet_rx
// PURPOSE
//  Next-generation UART packet receiver for the dual-image upgrade path. Deserialises rxd bytes
//  and frames packets as SYNC, CMD, LEN, LEN payload bytes, [CHK]. Payload goes to an external
//  buffer RAM write port. Aborts on parity, framing, length or inter-byte timeout errors and
//  reports a coded error. Sits between the rxd pin and the upgrade command decoder.
// PARAMETERS
//  CLOCK      50_000_000  clk frequency, Hz
//  BAUD       115_200     line rate; CPB = CLOCK/BAUD clocks per bit (integer division)
//  PARITY     "NO"        "NO" | "EVEN" | "ODD"
//  FIRST_BIT  "LSB"       "LSB" | "MSB" bit order on the line
//  NUMBER     256         payload buffer depth (bytes); max accepted LEN
//  TIMEOUT    10          inter-byte timeout in bit periods (0 = timeout disabled)
//  SYNC_BYTE  8'hA5       packet start marker
// PORTS
//  clk        in   1              system clock
//  reset      in   1              asynchronous, active-low reset
//  rxd        in   1              serial input, idle high, asynchronous to clk
//  rx_done    out  1              1-cycle pulse: packet accepted
//  rx_err     out  1              1-cycle pulse: packet aborted
//  err_code   out  3              cause of last abort; held until next abort
//  cmd_rx     out  8              CMD of last accepted packet
//  len_rx     out  8              LEN of last accepted packet
//  wr_data    out  8              payload byte
//  wr_addr    out  clogb2(NUMBER) payload byte index
//  we         out  1              1-cycle write strobe
//  byte_done  out  1              1-cycle pulse per received byte (debug/LED)
//  busy       out  1              high while framer is not in S_HUNT
// BEHAVIOUR
//  - Reset: every output 0; FSM in S_HUNT; internal CMD/LEN shadows 0.
//  - rxd passes a 2-FF synchroniser. The start edge is qualified low at CPB/2.
//  - Data, parity and stop bits are each sampled at mid-bit.
//  - Stop bit sampled 0: E_FRAME. Parity mismatch: E_PARITY.
//  - byte_done pulses in the stop-bit sample cycle N. Errored bytes still pulse byte_done.
//  - Framer FSM, advancing on byte_done:
//      S_HUNT: discards bytes until SYNC_BYTE is seen -> S_CMD.
//      S_CMD -> S_LEN.
//      S_LEN: if LEN > NUMBER -> abort E_LEN.
//             else if LEN == 0 -> S_CHK (S_HUNT + done without the macro).
//             else -> S_DATA.
//      S_DATA: on each byte, we = 1 at cycle N+1 with wr_addr = index (0..LEN-1) and
//              wr_data = byte. After byte LEN-1 -> S_CHK (or done).
//  - Done: rx_done pulses at N+1 of the final byte; cmd_rx/len_rx update in that same cycle
//    and are held until the next accepted packet. FSM returns to S_HUNT.
//  - Abort: rx_err pulses one cycle, err_code is updated, FSM returns to S_HUNT. Payload
//    already written stays in RAM; the consumer must ignore it.
//  - Timeout: counter clears on byte_done and whenever the framer is in S_HUNT. If it reaches
//    TIMEOUT*CPB while not in S_HUNT and no byte is in progress -> abort E_TIMEOUT.
//    byte_done in the same cycle as expiry wins: the counter clears and there is no abort.
//  - SYNC_BYTE seen mid-packet is treated as data, not a resync.
//  - Reset asserted mid-packet: immediate return to reset state; no rx_done or rx_err pulse.
//  - wr_addr never wraps, because LEN <= NUMBER is enforced before any write.
// CONFIGURATION
//  - RX_CHECKSUM_EN defined: a trailing CHK byte is expected (S_CHK).
//      Accept if CHK == (CMD + LEN + sum of payload) mod 256; otherwise abort E_CHKSUM.
//  - RX_CHECKSUM_EN undefined: no CHK byte; S_CHK and the sum register are not built.
//      The packet completes on the last payload byte, or on LEN when LEN == 0.
// STRUCTURE
//  - Package uart_rx_pkg:
//      state_t enum S_HUNT, S_CMD, S_LEN, S_DATA, S_CHK
//      err_t 3-bit codes E_NONE=0, E_PARITY=1, E_FRAME=2, E_LEN=3, E_TIMEOUT=4, E_CHKSUM=5
//      function clogb2
//  - Sub-module uart_rx_byte: synchroniser, bit timing, parity/stop check.
//      Outputs data[7:0], done, busy, perr, ferr.
//  - Framer, timeout counter and checksum stay in uart_packet_rx.
// TESTING  (CLOCK=1_000_000, BAUD=100_000 -> CPB=10; NUMBER=16; TIMEOUT=4; PARITY="EVEN")
//  1. A5 01 03 11 22 33 [CHK 0x6A]: we x3 at addr 0,1,2 with data 11,22,33;
//     rx_done=1, cmd_rx=01, len_rx=03.
//  2. Same packet with CHK=0x00 (macro on): no rx_done, rx_err=1, err_code=5;
//     next good packet is accepted.
//  3. A5 02 11 (LEN 17 > 16): rx_err at N+1 of the LEN byte, err_code=3, no we.
//  4. A5 01 02 11, then idle 60 clks: rx_err, err_code=4, busy=0.
//     Gap of 39 idle clks between bytes: no timeout.
//  5. Byte with a wrong parity bit during S_DATA: err_code=1. Stop bit forced 0: err_code=2.
//  6. Noise 00 FF then A5 07 00 [CHK 07]: leading bytes ignored; rx_done with len_rx=0, no we.
//     Reset pulled low mid-payload: all outputs 0, no pulses.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state/error encodings and sizing helper for the UART packet receiver.
package uart_rx_pkg;
    typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_DATA, S_CHK} state_t;
    typedef enum logic [2:0] {
        E_NONE = 3'd0, E_PARITY = 3'd1, E_FRAME = 3'd2,
        E_LEN = 3'd3, E_TIMEOUT = 3'd4, E_CHKSUM = 3'd5
    } err_t;
    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PAR, B_STOP} bstate_t;
    function automatic int clogb2(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_packet_rx_if.sv
// uart_packet_rx_if: serial input plus packet status and payload write port of the receiver.
interface uart_packet_rx_if #(parameter int AW = 8);
    logic          rxd;
    logic          rx_done;
    logic          rx_err;
    logic [2:0]    err_code;
    logic [7:0]    cmd_rx;
    logic [7:0]    len_rx;
    logic [7:0]    wr_data;
    logic [AW-1:0] wr_addr;
    logic          we;
    logic          byte_done;
    logic          busy;
    modport master (output rxd, input rx_done, rx_err, err_code, cmd_rx, len_rx, wr_data, wr_addr, we, byte_done, busy);
    modport slave  (input rxd, output rx_done, rx_err, err_code, cmd_rx, len_rx, wr_data, wr_addr, we, byte_done, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronises rxd, times bits from the start edge and checks parity and stop bit.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int    CPB       = 434,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       perr_o,
    output logic       ferr_o
);
    localparam int CW = $clog2(CPB + 1);
    localparam bit PAR_EN = PARITY != "NO";
    localparam bit ODD = PARITY == "ODD";
    localparam bit MSB = FIRST_BIT == "MSB";

    bstate_t       st_q;
    logic [1:0]    sync_q;
    logic          prev_q, par_q, rx, half, tick;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;

    assign rx     = sync_q[1];
    assign half   = cnt_q == CW'(CPB / 2 - 1);
    assign tick   = cnt_q == CW'(CPB - 1);
    assign busy_o = st_q != B_IDLE;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st_q   <= B_IDLE;
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            par_q  <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            data_o <= '0;
            done_o <= 1'b0;
            perr_o <= 1'b0;
            ferr_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            prev_q <= rx;
            done_o <= 1'b0;
            cnt_q  <= (st_q == B_IDLE || (st_q == B_START ? half : tick)) ? '0 : cnt_q + 1'b1;
            // A start needs a falling edge, so a low line after a framing error is not re-taken
            case (st_q)
                B_IDLE:  if (!rx && prev_q) st_q <= B_START;
                B_START: if (half) st_q <= rx ? B_IDLE : B_DATA;
                B_DATA:  if (tick) begin
                    sh_q  <= MSB ? {sh_q[6:0], rx} : {rx, sh_q[7:1]};
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) st_q <= PAR_EN ? B_PAR : B_STOP;
                end
                B_PAR:   if (tick) begin
                    par_q <= rx;
                    st_q  <= B_STOP;
                end
                default: if (tick) begin
                    st_q   <= B_IDLE;
                    done_o <= 1'b1;
                    data_o <= sh_q;
                    ferr_o <= !rx;
                    perr_o <= PAR_EN && (par_q != (^sh_q ^ ODD));
                end
            endcase
        end
endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: frames SYNC/CMD/LEN/payload packets from rxd into a buffer write port.
// Define RX_CHECKSUM_EN to require a trailing CHK byte (CMD + LEN + payload, mod 256).
module uart_packet_rx
    import uart_rx_pkg::*;
#(
    parameter int          CLOCK     = 50_000_000,
    parameter int          BAUD      = 115_200,
    parameter string       PARITY    = "NO",
    parameter string       FIRST_BIT = "LSB",
    parameter int          NUMBER    = 256,
    parameter int          TIMEOUT   = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input logic             clk,
    input logic             reset,
    uart_packet_rx_if.slave p
);
    localparam int CPB = CLOCK / BAUD;
    localparam int AW = clogb2(NUMBER);
    localparam int TO_CYC = TIMEOUT * CPB;
    localparam int TW = $clog2(TO_CYC + 2);

    state_t        st_q;
    err_t          err_q;
    logic [7:0]    bdata, cmd_q, len_q, cmd_rx_q, len_rx_q, wdata_q;
    logic          bdone, bbusy, perr, ferr, done_q, rerr_q, we_q, to_hit, last;
    logic [AW-1:0] idx_q, waddr_q;
    logic [TW-1:0] tcnt_q;
`ifdef RX_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    uart_rx_byte #(.CPB(CPB), .PARITY(PARITY), .FIRST_BIT(FIRST_BIT)) u_byte (
        .clk    (clk),
        .reset  (reset),
        .rxd_i  (p.rxd),
        .data_o (bdata),
        .done_o (bdone),
        .busy_o (bbusy),
        .perr_o (perr),
        .ferr_o (ferr)
    );

    // A byte completing in the expiry cycle clears the counter instead of aborting
    assign to_hit = TIMEOUT != 0 && st_q != S_HUNT && !bbusy && !bdone && tcnt_q == TW'(TO_CYC - 1);
    assign last   = 8'(idx_q) == len_q - 8'd1;

    assign p.rx_done   = done_q;
    assign p.rx_err    = rerr_q;
    assign p.err_code  = err_q;
    assign p.cmd_rx    = cmd_rx_q;
    assign p.len_rx    = len_rx_q;
    assign p.wr_data   = wdata_q;
    assign p.wr_addr   = waddr_q;
    assign p.we        = we_q;
    assign p.byte_done = bdone;
    assign p.busy      = st_q != S_HUNT;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st_q     <= S_HUNT;
            err_q    <= E_NONE;
            done_q   <= 1'b0;
            rerr_q   <= 1'b0;
            we_q     <= 1'b0;
            cmd_q    <= '0;
            len_q    <= '0;
            cmd_rx_q <= '0;
            len_rx_q <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            waddr_q  <= '0;
            tcnt_q   <= '0;
`ifdef RX_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            rerr_q <= 1'b0;
            we_q   <= 1'b0;
            tcnt_q <= (st_q == S_HUNT || bdone) ? '0 : tcnt_q + TW'(!bbusy);
            if (to_hit) begin
                rerr_q <= 1'b1;
                err_q  <= E_TIMEOUT;
                st_q   <= S_HUNT;
            end else if (bdone) begin
`ifdef RX_CHECKSUM_EN
                sum_q <= st_q == S_CMD ? bdata : sum_q + bdata;
`endif
                if (st_q != S_HUNT && (ferr || perr)) begin
                    rerr_q <= 1'b1;
                    err_q  <= ferr ? E_FRAME : E_PARITY;
                    st_q   <= S_HUNT;
                end else case (st_q)
                    S_HUNT: if (bdata == SYNC_BYTE && !ferr && !perr) st_q <= S_CMD;
                    S_CMD: begin
                        cmd_q <= bdata;
                        st_q  <= S_LEN;
                    end
                    S_LEN: begin
                        len_q <= bdata;
                        idx_q <= '0;
                        if (32'(bdata) > NUMBER) begin
                            rerr_q <= 1'b1;
                            err_q  <= E_LEN;
                            st_q   <= S_HUNT;
                        end else if (bdata != 8'd0) st_q <= S_DATA;
`ifdef RX_CHECKSUM_EN
                        else st_q <= S_CHK;
`else
                        else begin
                            done_q   <= 1'b1;
                            cmd_rx_q <= cmd_q;
                            len_rx_q <= 8'd0;
                            st_q     <= S_HUNT;
                        end
`endif
                    end
                    S_DATA: begin
                        we_q    <= 1'b1;
                        waddr_q <= idx_q;
                        wdata_q <= bdata;
                        idx_q   <= idx_q + 1'b1;
`ifdef RX_CHECKSUM_EN
                        if (last) st_q <= S_CHK;
`else
                        if (last) begin
                            done_q   <= 1'b1;
                            cmd_rx_q <= cmd_q;
                            len_rx_q <= len_q;
                            st_q     <= S_HUNT;
                        end
`endif
                    end
`ifdef RX_CHECKSUM_EN
                    default: begin
                        st_q <= S_HUNT;
                        if (bdata == sum_q) begin
                            done_q   <= 1'b1;
                            cmd_rx_q <= cmd_q;
                            len_rx_q <= len_q;
                        end else begin
                            rerr_q <= 1'b1;
                            err_q  <= E_CHKSUM;
                        end
                    end
`else
                    default: st_q <= S_HUNT;
`endif
                endcase
            end
        end
endmodule
